axis_phase_gen: RTL and testbench

AXIS_PHASE_GEN -- requirements
Module: axis_phase_gen

---
 rtl/cordic_pkg.sv | 18 +
 rtl/phase_wrap.sv | 34 +++
 rtl/axis_phase_gen.sv | 91 +++++++++
 tb/tb_axis_phase_gen.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cordic_pkg.sv
// Shared phase-format constants and the phase generator FSM state type.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cordic_pkg;

    // Phases are signed Q3.29 radians carried on a 32-bit bus.
    localparam int PHASE_W = 32;

    // PI and 2*PI in Q3.29, sized for the 34-bit signed wrap intermediate.
    localparam logic signed [33:0] PHASE_PI     = 34'sd1686629713;
    localparam logic signed [33:0] PHASE_TWO_PI = 34'sd3373259426;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/phase_wrap.sv
// Next-phase adder: phase + step, folded into [-PI, PI] when PHASE_GEN_WRAP_EN is defined.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to consume next_phase.
module phase_wrap
    import cordic_pkg::*;
(
    input  logic [PHASE_W-1:0] phase,
    input  logic [PHASE_W-1:0] step,
    output logic [PHASE_W-1:0] next_phase
);

`ifdef PHASE_GEN_WRAP_EN
    logic signed [33:0] sum;
    logic signed [33:0] wrapped;

    // Sign-extend both operands so the sum cannot overflow, then fold by one turn.
    always_comb begin
        sum     = $signed({{2{phase[PHASE_W-1]}}, phase}) + $signed({{2{step[PHASE_W-1]}}, step});
        wrapped = sum;
        if (sum > PHASE_PI) begin
            wrapped = sum - PHASE_TWO_PI;
        end else if (sum < -PHASE_PI) begin
            wrapped = sum + PHASE_TWO_PI;
        end
        next_phase = wrapped[PHASE_W-1:0];
    end
`else
    // Plain two's-complement accumulation; the carry out is simply discarded.
    always_comb begin
        next_phase = phase + step;
    end
`endif

endmodule

// File: rtl/axis_phase_gen.sv
// AXI-Stream phase ramp generator: emits cfg_count beats of phase0 + k*step (wrapped when PHASE_GEN_WRAP_EN is defined).
// Latency: first beat valid the cycle after start is accepted; one beat per cycle while tready is high; done the cycle after the last beat.
// Backpressure: tdata/tlast hold while tvalid && !tready; start is ignored until the burst completes.
module axis_phase_gen
    import cordic_pkg::*;
#(
    parameter int COUNT_W = 16
)
(
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [31:0]        cfg_phase0,
    input  logic [31:0]        cfg_step,
    input  logic [COUNT_W-1:0] cfg_count,
    output logic               busy,
    output logic               done,
    output logic [31:0]        m_axis_tdata,
    output logic               m_axis_tvalid,
    input  logic               m_axis_tready,
    output logic               m_axis_tlast
);

    state_t               state;
    logic [PHASE_W-1:0]   step_q;
    logic [COUNT_W-1:0]   count_q;
    logic [COUNT_W-1:0]   beat_q;     // 1-based index of the beat currently on the bus
    logic [PHASE_W-1:0]   next_phase;

    phase_wrap u_phase_wrap (
        .phase      (m_axis_tdata),
        .step       (step_q),
        .next_phase (next_phase)
    );

    // busy is a pure decode of the state register, so reset clears it immediately.
    assign busy = (state == ST_RUN);

    // Burst sequencer: accept start in IDLE, advance one beat per handshake in RUN.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= ST_IDLE;
            step_q        <= '0;
            count_q       <= '0;
            beat_q        <= '0;
            m_axis_tdata  <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            done          <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        step_q  <= cfg_step;
                        count_q <= cfg_count;
                        if (cfg_count != '0) begin
                            state         <= ST_RUN;
                            m_axis_tvalid <= 1'b1;
                            m_axis_tdata  <= cfg_phase0;
                            m_axis_tlast  <= (cfg_count == COUNT_W'(1));
                            beat_q        <= COUNT_W'(1);
                        end else begin
                            // Empty burst: report completion without emitting anything.
                            done <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    // tvalid is always high in RUN, so tready alone marks a handshake.
                    if (m_axis_tready) begin
                        if (m_axis_tlast) begin
                            state         <= ST_IDLE;
                            m_axis_tvalid <= 1'b0;
                            m_axis_tlast  <= 1'b0;
                            done          <= 1'b1;
                        end else begin
                            m_axis_tdata <= next_phase;
                            beat_q       <= beat_q + COUNT_W'(1);
                            m_axis_tlast <= ((beat_q + COUNT_W'(1)) == count_q);
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axis_phase_gen.sv
// Scoreboard bench for axis_phase_gen: stimulus pushes expected beats, a negedge monitor pops and compares.
// Latency: n/a.
// Backpressure: tready driven from a script queue or randomly per burst.
module tb_axis_phase_gen;

    localparam longint PI     = 64'sd1686629713;
    localparam longint TWO_PI = 64'sd3373259426;

    typedef struct {
        logic [31:0] d;
        logic        l;
    } beat_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [31:0] cfg_phase0 = '0;
    logic [31:0] cfg_step = '0;
    logic [15:0] cfg_count = '0;
    logic        busy;
    logic        done;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready = 1'b1;
    logic        m_axis_tlast;

    axis_phase_gen #(.COUNT_W(16)) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .cfg_phase0    (cfg_phase0),
        .cfg_step      (cfg_step),
        .cfg_count     (cfg_count),
        .busy          (busy),
        .done          (done),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast)
    );

    always #5 clk = ~clk;

    int chk_cnt = 0;
    int pass_cnt = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    beat_t       exp_q[$];
    logic [31:0] hs_log[$];
    bit          ready_script[$];
    int          ready_mode = 0;   // 0: always ready, 1: random
    int          done_pend = 0;
    int          first_vld_cyc = -1;
    int          stall_cnt = 0;
    bit          vld_seen = 1'b0;

    task automatic chk(input bit ok, input string nm, input longint act, input longint expv);
        chk_cnt++;
        if (ok) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, expv, $time);
    endtask

    // Reference wrap rule taken straight from the phase arithmetic definition.
    function automatic longint wrap_m(input longint s);
`ifdef PHASE_GEN_WRAP_EN
        if (s > PI) return s - TWO_PI;
        if (s < -PI) return s + TWO_PI;
        return s;
`else
        int t;
        t = int'(s);
        return longint'(t);
`endif
    endfunction

    // tready driver: runs after stimulus in each cycle so a freshly pushed script takes effect.
    always begin
        @(posedge clk);
        #2;
        if (ready_script.size() > 0) m_axis_tready = ready_script.pop_front();
        else if (ready_mode == 0) m_axis_tready = 1'b1;
        else m_axis_tready = 1'($urandom_range(1, 0));
    end

    // Monitor: scoreboard pops, hold-stability, busy/tvalid agreement, done accounting.
    bit          prev_stall = 1'b0;
    bit          prev_vld = 1'b0;
    logic [31:0] prev_data = '0;
    logic        prev_last = 1'b0;
    always @(negedge clk) begin
        if (reset) begin
            chk(!m_axis_tvalid && !m_axis_tlast && m_axis_tdata == 32'd0 && !done && !busy,
                "reset_outputs", {m_axis_tvalid, m_axis_tlast, done, busy, m_axis_tdata}, 0);
            prev_stall = 1'b0;
            prev_vld = 1'b0;
        end else begin
            chk(busy == m_axis_tvalid, "busy_eq_state_run", busy, m_axis_tvalid);
            if (prev_stall)
                chk(m_axis_tvalid && m_axis_tdata == prev_data && m_axis_tlast == prev_last,
                    "hold_stable", m_axis_tdata, prev_data);
            if (m_axis_tvalid && !prev_vld) first_vld_cyc = cyc;
            if (m_axis_tvalid) vld_seen = 1'b1;
            if (m_axis_tvalid && !m_axis_tready) stall_cnt++;
            if (m_axis_tvalid && m_axis_tready) begin
                hs_log.push_back(m_axis_tdata);
                if (exp_q.size() == 0) begin
                    chk(1'b0, "extra_beat", m_axis_tdata, 0);
                end else begin
                    beat_t e;
                    e = exp_q.pop_front();
                    chk(m_axis_tdata == e.d, "tdata", m_axis_tdata, e.d);
                    chk(m_axis_tlast == e.l, "tlast", m_axis_tlast, e.l);
                end
            end
            if (done) begin
                chk(done_pend > 0, "unexpected_done", done_pend, 1);
                if (done_pend > 0) done_pend--;
            end
            prev_stall = m_axis_tvalid && !m_axis_tready;
            prev_vld = m_axis_tvalid;
            prev_data = m_axis_tdata;
            prev_last = m_axis_tlast;
        end
    end

    // Issue one burst (caller is positioned 1 time unit after a rising edge) and wait for done.
    task automatic run_burst(input logic [31:0] p0, input logic [31:0] st, input int n,
                             input int rmode, input bit timed, input bit poke);
        int     sc;
        bit     got;
        longint p;
        hs_log.delete();
        stall_cnt = 0;
        vld_seen = 1'b0;
        first_vld_cyc = -1;
        ready_mode = rmode;
        p = longint'($signed(p0));
        for (int k = 0; k < n; k++) begin
            beat_t b;
            b.d = p[31:0];
            b.l = (k == n - 1);
            exp_q.push_back(b);
            p = wrap_m(p + longint'($signed(st)));
        end
        done_pend++;
        cfg_phase0 = p0;
        cfg_step = st;
        cfg_count = 16'(n);
        start = 1'b1;
        sc = cyc;
        @(posedge clk);
        #1;
        start = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (done) begin
                got = 1'b1;
                break;
            end
            if (poke && i == 1) begin
                start = 1'b1;
                cfg_count = 16'd3;
                cfg_step = 32'h1;
            end
            if (poke && i == 2) start = 1'b0;
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        chk(got, "done_timeout", got, 1);
        if (got) begin
            chk(exp_q.size() == 0, "beats_outstanding", exp_q.size(), 0);
            if (timed) chk(cyc == sc + n + 1, "done_cycle", cyc - sc, n + 1);
            if (n > 0) chk(first_vld_cyc == sc + 1, "tvalid_rise", first_vld_cyc - sc, 1);
        end
    endtask

    initial begin
        longint r;
        // Power-up reset; monitor checks outputs each cycle while held.
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Basic ramp with tready held high.
        run_burst(32'h0, 32'h2000_0000, 4, 0, 1'b1, 1'b0);
        chk(hs_log.size() == 4, "basic_beats", hs_log.size(), 4);
        for (int k = 0; k < 4 && k < hs_log.size(); k++)
            chk(hs_log[k] == 32'(k * 32'h2000_0000), "basic_value", hs_log[k], k * 32'h2000_0000);

        // Wrap behaviour on the second beat.
        run_burst(32'd1686629713, 32'd843314857, 2, 0, 1'b1, 1'b0);
        chk(hs_log.size() == 2, "wrap_beats", hs_log.size(), 2);
        if (hs_log.size() == 2) begin
`ifdef PHASE_GEN_WRAP_EN
            chk($signed(hs_log[1]) == -32'sd843314856, "wrap_second", $signed(hs_log[1]), -843314856);
`else
            chk($signed(hs_log[1]) == -32'sd1765022726, "trunc_second", $signed(hs_log[1]), -1765022726);
`endif
        end

        // Backpressure: three stall cycles on beat 2 of a three-beat burst.
        ready_script.push_back(1'b1);
        ready_script.push_back(1'b1);
        ready_script.push_back(1'b0);
        ready_script.push_back(1'b0);
        ready_script.push_back(1'b0);
        run_burst(32'h100, 32'h1000, 3, 0, 1'b0, 1'b0);
        chk(hs_log.size() == 3, "bp_beats", hs_log.size(), 3);
        chk(stall_cnt == 3, "bp_stalls", stall_cnt, 3);

        // Zero-length burst.
        run_burst(32'h5, 32'h5, 0, 0, 1'b1, 1'b0);
        chk(!busy, "count0_busy", busy, 0);
        chk(!vld_seen, "count0_no_tvalid", vld_seen, 0);

        // Start during RUN ignored, then start in the done cycle accepted.
        run_burst(32'h0, 32'd1000, 5, 0, 1'b1, 1'b1);
        run_burst(32'h7, 32'h3, 2, 0, 1'b1, 1'b0);
        chk(hs_log.size() == 2, "b2b_beats", hs_log.size(), 2);

        // Reset in the middle of an 8-beat burst.
        hs_log.delete();
        begin
            longint p;
            p = 0;
            for (int k = 0; k < 8; k++) begin
                beat_t b;
                b.d = p[31:0];
                b.l = (k == 7);
                exp_q.push_back(b);
                p = wrap_m(p + 1000);
            end
        end
        done_pend++;
        ready_mode = 0;
        cfg_phase0 = 32'h0;
        cfg_step = 32'd1000;
        cfg_count = 16'd8;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int i = 0; i < 50 && hs_log.size() < 2; i++) begin
            @(posedge clk);
            #1;
        end
        chk(hs_log.size() == 2, "mid_reset_prebeats", hs_log.size(), 2);
        reset = 1'b1;
        #1;
        chk(!m_axis_tvalid && !busy, "async_reset", {m_axis_tvalid, busy}, 0);
        exp_q.delete();
        done_pend = 0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        run_burst(32'h1234, 32'h10, 2, 0, 1'b1, 1'b0);
        chk(hs_log.size() == 2, "post_reset_beats", hs_log.size(), 2);

        // Randomized bursts against the reference ramp.
        for (int t = 0; t < 25; t++) begin
            logic [31:0] p0;
            logic [31:0] st;
            r = longint'($urandom_range(32'd3373259426, 32'd0)) - PI;
            p0 = r[31:0];
            r = longint'($urandom_range(32'd3373259426, 32'd0)) - PI;
            st = r[31:0];
            run_burst(p0, st, int'($urandom_range(6, 0)), int'($urandom_range(1, 0)), 1'b0, 1'b0);
            repeat ($urandom_range(2, 0)) begin
                @(posedge clk);
                #1;
            end
        end

        repeat (4) @(posedge clk);
        chk(exp_q.size() == 0 && done_pend == 0, "final_drain", exp_q.size() + done_pend, 0);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
